// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, combinational imem lookup, IF/ID capture; one-cycle fetch latency.
// Stall holds PC and IF/ID; redirect outranks stall and squashes IF/ID; HALT_INST freezes fetch until redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_INST  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t      r_state,     w_state_nxt;
  logic [31:0] r_pc,        w_pc_nxt;
  logic [31:0] r_id_inst,   w_id_inst_nxt;
  logic [31:0] r_id_pc,     w_id_pc_nxt;
  logic [31:0] r_id_pc4,    w_id_pc4_nxt;
  logic        r_id_valid,  w_id_valid_nxt;
  logic [31:0] r_fcnt,      w_fcnt_nxt;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_id_inst  <= NOP_INST;
      r_id_pc    <= 32'h0;
      r_id_pc4   <= 32'h0;
      r_id_valid <= 1'b0;
      r_fcnt     <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_id_inst  <= w_id_inst_nxt;
      r_id_pc    <= w_id_pc_nxt;
      r_id_pc4   <= w_id_pc4_nxt;
      r_id_valid <= w_id_valid_nxt;
      r_fcnt     <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_id_inst_nxt  = r_id_inst;
    w_id_pc_nxt    = r_id_pc;
    w_id_pc4_nxt   = r_id_pc4;
    w_id_valid_nxt = r_id_valid;
    w_fcnt_nxt     = r_fcnt;
    // Bubbles leave id_pc/id_pc_plus4 untouched; consumers qualify with id_valid.
    if (redirect) begin
      w_pc_nxt       = redirect_pc & ~32'h3;
      w_id_inst_nxt  = NOP_INST;
      w_id_valid_nxt = 1'b0;
      w_state_nxt    = ST_RUN;
    end else if (stall) begin
      w_state_nxt = r_state;
    end else if (r_state == ST_HALT) begin
      w_id_inst_nxt  = NOP_INST;
      w_id_valid_nxt = 1'b0;
    end else if (imem_inst == HALT_INST) begin
      w_id_inst_nxt  = NOP_INST;
      w_id_valid_nxt = 1'b0;
      w_state_nxt    = ST_HALT;
    end else begin
      w_id_inst_nxt  = imem_inst;
      w_id_pc_nxt    = r_pc;
      w_id_pc4_nxt   = w_pc_plus4;
      w_id_valid_nxt = 1'b1;
      w_pc_nxt       = w_pc_plus4;
      w_fcnt_nxt     = r_fcnt + 32'd1;
    end
  end

  assign imem_addr   = r_pc;
  assign id_inst     = r_id_inst;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc4;
  assign id_valid    = r_id_valid;
  assign halted      = (r_state == ST_HALT);
  assign fetch_count = r_fcnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/halt traffic against a cycle model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic [31:0] id_inst, id_pc, id_pc_plus4, fetch_count;
  logic        id_valid, halted;

  int n_total = 0;
  int n_pass  = 0;

  // Memory image: word n holds 0x1000_0000 + n, optionally one address returns the halt marker.
  logic        halt_en   = 1'b0;
  logic [31:0] halt_addr = 32'h0;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    if (halt_en && a == halt_addr) return 32'hFFFF_FFFF;
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_inst = mem_of(imem_addr);

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_valid(id_valid), .halted(halted), .fetch_count(fetch_count)
  );

  // Reference model state
  logic [31:0] m_pc, m_inst, m_idpc, m_idpc4, m_cnt;
  logic        m_valid, m_halt;

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_idpc = 32'h0; m_idpc4 = 32'h0;
    m_cnt = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step(input logic st, input logic rd, input logic [31:0] rpc);
    logic [31:0] w;
    w = mem_of(m_pc);
    if (rd) begin
      m_pc = {rpc[31:2], 2'b00}; m_inst = 32'h0; m_valid = 1'b0; m_halt = 1'b0;
    end else if (st) begin
      m_pc = m_pc;
    end else if (m_halt || w == 32'hFFFF_FFFF) begin
      m_inst = 32'h0; m_valid = 1'b0; m_halt = 1'b1;
    end else begin
      m_inst = w; m_idpc = m_pc; m_idpc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imem_addr"},   imem_addr,          m_pc);
    chk({tag, ".id_inst"},     id_inst,            m_inst);
    chk({tag, ".id_pc"},       id_pc,              m_idpc);
    chk({tag, ".id_pc_plus4"}, id_pc_plus4,        m_idpc4);
    chk({tag, ".id_valid"},    {31'h0, id_valid},  {31'h0, m_valid});
    chk({tag, ".halted"},      {31'h0, halted},    {31'h0, m_halt});
    chk({tag, ".fetch_count"}, fetch_count,        m_cnt);
  endtask

  task automatic cycle(input string tag, input logic st, input logic rd, input logic [31:0] rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    #1;
    model_step(st, rd, rpc);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Sequential fetch
    for (int k = 1; k <= 2; k++) cycle("seq", 1'b0, 1'b0, 32'h0);
    chk("seq.k2_inst", id_inst, 32'h1000_0001);

    // Stall two cycles at imem_addr 0x8
    cycle("stall", 1'b1, 1'b0, 32'h0);
    cycle("stall", 1'b1, 1'b0, 32'h0);
    chk("stall.addr_hold", imem_addr, 32'h8);
    chk("stall.idpc_hold", id_pc, 32'h4);
    cycle("stall_rel", 1'b0, 1'b0, 32'h0);
    chk("stall.resume", imem_addr, 32'hC);

    // Redirect outranks stall; low bits of target dropped
    cycle("redir_stall", 1'b1, 1'b1, 32'h23);
    chk("redir.addr", imem_addr, 32'h20);
    chk("redir.bubble", {31'h0, id_valid}, 32'h0);
    cycle("redir_tgt", 1'b0, 1'b0, 32'h0);
    chk("redir.idpc", id_pc, 32'h20);

    // Halt marker at 0x10
    halt_en = 1'b1; halt_addr = 32'h10;
    cycle("to0", 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 5; i++) cycle("run_to_halt", 1'b0, 1'b0, 32'h0);
    chk("halt.flag", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 5; i++) cycle("halted", 1'b0, 1'b0, 32'h0);
    chk("halt.addr", imem_addr, 32'h10);
    chk("halt.count", fetch_count, 32'h4 + 32'h4);
    cycle("unhalt", 1'b0, 1'b1, 32'h0);
    chk("unhalt.flag", {31'h0, halted}, 32'h0);
    halt_en = 1'b0;

    // PC wrap
    cycle("wrap_redir", 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle("wrap", 1'b0, 1'b0, 32'h0);
    chk("wrap.addr", imem_addr, 32'h0);
    chk("wrap.pc4", id_pc_plus4, 32'h0);

    // Async reset between edges at pc 0x30
    cycle("to2c", 1'b0, 1'b1, 32'h2C);
    cycle("to30", 1'b0, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("async_rst_hold");
    rst_n = 1'b1;
    cycle("post_rst", 1'b0, 1'b0, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic st, rd;
      logic [31:0] rpc;
      if (($urandom % 16) == 0) begin
        halt_en   = $urandom_range(0, 1);
        halt_addr = {22'h0, 8'($urandom_range(0, 63)), 2'b00};
      end
      st  = (($urandom % 4) == 0);
      rd  = (($urandom % 10) == 0);
      rpc = (($urandom % 8) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
      cycle("rand", st, rd, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
